// File: rtl/sync_fifo32.sv
// sync_fifo32: single-clock FIFO with a registered read port and
// EMPTY/FULL flags decoded from a registered occupancy count.
// Reset is synchronous and active-low, and it overrides the enable.
// When en is low, every piece of state holds, including dataOut.
module sync_fifo32 #(
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             EMPTY,
  output logic             FULL
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count;
  logic [WIDTH-1:0]  dout_q;
  logic              rd_ok;
  logic              wr_ok;

  // Flags come only from the registered count, so rd and wr cannot make them glitch.
  assign EMPTY   = (count == '0);
  assign FULL    = (count == CNT_FULL);
  assign dataOut = dout_q;

  // A read that happens in the same cycle frees a slot, so a full FIFO
  // can still accept a write. An empty FIFO has no fall-through path.
  always_comb begin
    rd_ok = rd & ~EMPTY;
    wr_ok = wr & (~FULL | rd_ok);
  end

  // Storage has no reset. Writes are still suppressed while rst is low,
  // so any word in flight at reset is discarded.
  always_ff @(posedge clk) begin
    if (rst && en && wr_ok) begin
      mem[wptr] <= dataIn;
    end
  end

  // Pointers, count and the read register. Reset takes priority,
  // then the enable, then normal operation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      dout_q <= '0;
    end else if (en) begin
      if (wr_ok) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_ok) begin
        dout_q <= mem[rptr];
        rptr   <= rptr + PTR_ONE;
      end
      if (wr_ok && !rd_ok) begin
        count <= count + CNT_ONE;
      end else if (rd_ok && !wr_ok) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo32.sv
// tb_sync_fifo32: directed scoreboard bench for sync_fifo32.
// The stimulus queues the hand-computed dataOut/EMPTY/FULL expected after
// each edge, and the monitor pops and compares them on the falling edge.
module tb_sync_fifo32;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic         wr  = 1'b0;
  logic         rd  = 1'b0;
  logic [W-1:0] dataIn = '0;
  logic [W-1:0] dataOut;
  logic         EMPTY;
  logic         FULL;

  sync_fifo32 #(.WIDTH(32), .DEPTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .wr      (wr),
    .rd      (rd),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .EMPTY   (EMPTY),
    .FULL    (FULL)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned  edge_no;
    logic [W-1:0] dout;
    logic         e;
    logic         f;
    string        name;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned edge_cnt    = 0;
  int          vectors     = 0;
  int          miscompares = 0;

  // Counts rising edges so each expectation is checked only after its own edge.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Scoreboard monitor: pops every expectation whose edge has already occurred.
  always @(negedge clk) begin
    exp_t x;
    while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
      x = exp_q.pop_front();
      vectors++;
      if (dataOut !== x.dout || EMPTY !== x.e || FULL !== x.f) begin
        miscompares++;
        $display("FAIL %s @edge %0d: got dataOut=%h EMPTY=%b FULL=%b, want dataOut=%h EMPTY=%b FULL=%b",
                 x.name, x.edge_no, dataOut, EMPTY, FULL, x.dout, x.e, x.f);
      end
    end
  end

  // Drives one cycle of inputs and queues the state expected after the next edge.
  task automatic cyc(input logic r, input logic e, input logic w, input logic rr,
                     input logic [W-1:0] d, input logic [W-1:0] xd,
                     input logic xe, input logic xf, input string nm);
    exp_t x;
    @(negedge clk);
    #1;
    rst    = r;
    en     = e;
    wr     = w;
    rd     = rr;
    dataIn = d;
    x.edge_no = edge_cnt + 1;
    x.dout    = xd;
    x.e       = xe;
    x.f       = xf;
    x.name    = nm;
    exp_q.push_back(x);
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b1;

    // reset, including wr/rd requests that reset must override
    cyc(0, 1, 0, 0, 32'h0,    32'h0, 1, 0, "reset0");
    cyc(0, 1, 1, 1, 32'hDEAD, 32'h0, 1, 0, "reset1");

    // fill 0..4, then drain in order; the sixth read hits empty
    for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0, 32'(i), 32'h0, 0, 0, "fill");
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 1, 32'h0, 32'(i), (i == 4), 0, "drain");
    cyc(1, 1, 0, 1, 32'h0, 32'h4, 1, 0, "drain_empty_rd");

    // fill to full, then overflow; 0xFF must never appear
    for (int i = 0; i < 8; i++)
      cyc(1, 1, 1, 0, 32'h10 + 32'(i), 32'h4, 0, (i == 7), "fill_full");
    cyc(1, 1, 1, 0, 32'hFF, 32'h4, 0, 1, "overflow_drop");

    // rd+wr while full: oldest word out, 0xAA in, count stays full
    cyc(1, 1, 1, 1, 32'hAA, 32'h10, 0, 1, "full_rdwr");
    for (int i = 0; i < 7; i++)
      cyc(1, 1, 0, 1, 32'h0, 32'h11 + 32'(i), 0, 0, "drain_full");
    cyc(1, 1, 0, 1, 32'h0, 32'hAA, 1, 0, "drain_last_aa");

    // rd+wr while empty: only the write is accepted, with no fall-through
    cyc(1, 1, 1, 1, 32'h55, 32'hAA, 0, 0, "empty_rdwr");
    cyc(1, 1, 0, 1, 32'h0,  32'h55, 1, 0, "read_55");

    // enable gating with three words stored
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 1, 0, 32'h31 + 32'(i), 32'h55, 0, 0, "fill3");
    for (int i = 0; i < 4; i++)
      cyc(1, 0, 1, 1, 32'hEE, 32'h55, 0, 0, "en_low");
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 0, 1, 32'h0, 32'h31 + 32'(i), (i == 2), 0, "en_resume");
    cyc(1, 1, 0, 1, 32'h0, 32'h33, 1, 0, "empty_rd_hold");

    // 20 writes and 20 reads streaming through several pointer wraps
    cyc(1, 1, 1, 0, 32'h100, 32'h33, 0, 0, "wrap_first");
    for (int k = 1; k < 20; k++)
      cyc(1, 1, 1, 1, 32'h100 + 32'(k), 32'h100 + 32'(k - 1), 0, 0, "wrap_stream");
    cyc(1, 1, 0, 1, 32'h0, 32'h113, 1, 0, "wrap_last");

    // reset in the middle of operation discards the stored words
    for (int i = 0; i < 4; i++)
      cyc(1, 1, 1, 0, 32'h201 + 32'(i), 32'h113, 0, 0, "prereset_fill");
    cyc(0, 1, 1, 1, 32'h2FF, 32'h0, 1, 0, "midop_reset");
    cyc(1, 1, 0, 1, 32'h0,   32'h0, 1, 0, "post_reset_rd");

    // reset also overrides en=0
    cyc(1, 1, 1, 0, 32'h77, 32'h0, 0, 0, "write_77");
    cyc(0, 0, 1, 1, 32'h88, 32'h0, 1, 0, "reset_over_en");
    cyc(1, 1, 0, 1, 32'h0,  32'h0, 1, 0, "final_rd_empty");

    // let the monitor consume the remaining expectations, with a bound
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d unchecked expectations, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_fifo32.md
Name: sync_fifo32

Overview:
- Single-clock, synchronous first-in-first-out buffer with a default width of 32 bits and a default depth of 8 entries.
- Sits between a producer and a consumer in the same clock domain.
- Provides a registered read-data output and EMPTY/FULL status flags.
- A global enable gates all state changes.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 8, number of storage entries; must be a power of 2 and at least 2.
- ADDR_W, log2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock; all state changes on this edge.
- rst  input  1  synchronous, active-low reset.
- en  input  1  global enable; 0 freezes all state, including dataOut.
- wr  input  1  write request.
- rd  input  1  read request.
- dataIn  input  WIDTH  write data, sampled at the clock edge when a write is accepted.
- dataOut  output  WIDTH  registered read data.
- EMPTY  output  1  high when the stored count is 0.
- FULL  output  1  high when the stored count equals DEPTH.

Behaviour:
- Internal state:
  - storage array of DEPTH x WIDTH;
  - write pointer and read pointer, each ADDR_W bits, wrapping modulo DEPTH;
  - occupancy count of ADDR_W+1 bits.
- Priority at each rising edge: rst=0 first, then en=0, then normal operation.
- Reset (rst=0 at the edge):
  - write pointer, read pointer and count go to 0;
  - dataOut goes to 0;
  - EMPTY=1 and FULL=0 from the following cycle;
  - storage contents are don't-care;
  - reset overrides en, rd and wr, including mid-operation; any data in flight is discarded.
- en=0: no pointer, count, storage or dataOut change; rd and wr are ignored.
- Write accept: wr_ok = wr & (~FULL | rd_ok).
  - On accept: mem[wptr] <= dataIn, then wptr increments.
- Read accept: rd_ok = rd & ~EMPTY.
  - On accept: dataOut <= mem[rptr], then rptr increments.
  - dataOut is valid on the cycle after the accepting edge.
  - dataOut holds its last value when no read is accepted.
- Count update:
  - +1 on write-only;
  - -1 on read-only;
  - unchanged when both are accepted or neither is.
- Flags:
  - EMPTY = (count == 0) and FULL = (count == DEPTH);
  - both are decoded from registered count, so they reflect state after the most recent edge;
  - no glitching from rd/wr inputs.
- Boundary conditions:
  - Empty with rd&wr: only the write is accepted. There is no fall-through, dataOut is unchanged, and count becomes 1.
  - Full with rd&wr: both are accepted. The oldest word goes to dataOut, the new word is stored, and count stays DEPTH.
  - Full with wr only: the write is dropped; storage and pointers are unchanged.
  - Empty with rd only: the read is ignored; dataOut holds.
  - Pointer wrap from DEPTH-1 to 0 is transparent; ordering is preserved across the wrap.
- Read latency: 1 cycle from the accepting edge to dataOut.
- Write-to-readable latency: a word written at edge N can be read at edge N+1, because EMPTY deasserts after edge N.

Test Plan:
- Reset and fill:
  - Hold rst=0 for 2 cycles with en=1 -> dataOut=0, EMPTY=1, FULL=0.
  - Release reset, write 0x0..0x4 on 5 consecutive cycles -> EMPTY=0 after the first write, count=5, FULL=0.
- Drain order:
  - After the fill above, rd=1 and wr=0 for 6 cycles -> dataOut = 0x0,0x1,0x2,0x3,0x4 on successive cycles.
  - EMPTY=1 after the 5th read; the 6th read is ignored and dataOut holds 0x4.
- Full and overflow:
  - Write 8 words 0x10..0x17 -> FULL=1.
  - A 9th write of 0xFF is dropped.
  - Reading 8 words returns 0x10..0x17, then EMPTY=1.
- Simultaneous rd/wr:
  - When full, rd=wr=1 with dataIn=0xAA -> dataOut=0x10, FULL stays 1, and 0xAA is read last.
  - When empty, rd=wr=1 with dataIn=0x55 -> dataOut unchanged, EMPTY=0, and the next read returns 0x55.
- Enable gating:
  - With 3 words stored, en=0 with rd=1 and wr=1 for 4 cycles -> dataOut, EMPTY, FULL and the contents are unchanged.
  - Restoring en=1 resumes reads in the original order.
- Wrap and mid-op reset:
  - Interleave 20 writes and reads of incrementing data -> no loss or reordering across pointer wrap.
  - Assert rst=0 with 4 words stored -> EMPTY=1 and dataOut=0 on the next cycle; prior data is unreadable.
